// File: rtl/gl_wb_arbiter.sv
// Writeback arbiter for the graduation list. Each requester gets a one-entry holding buffer.
// Held completions are granted round-robin onto the GL's two writeback ports, which are driven from flops.
module gl_wb_hold #(
  parameter int GL_IDX_W = 5,
  parameter int DATA_W   = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                load,
  input  logic                grant,
  input  logic [GL_IDX_W-1:0] idx,
  input  logic [DATA_W-1:0]   data,
  output logic                hv,
  output logic [GL_IDX_W-1:0] hidx,
  output logic [DATA_W-1:0]   hdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv    <= 1'b0;
      hidx  <= '0;
      hdata <= '0;
    end else begin
      // A reload wins over the clear of a granted entry, so the buffer stays full.
      if (flush)      hv <= 1'b0;
      else if (load)  hv <= 1'b1;
      else if (grant) hv <= 1'b0;
      if (load) begin
        hidx  <= idx;
        hdata <= data;
      end
    end
  end
endmodule

module gl_wb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GL_IDX_W = 5,
  parameter int DATA_W   = 40   // width of one gl_wb_data_t word
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*GL_IDX_W-1:0]   req_index_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_i,
  output logic [1:0]                    wb_enable_o,
  output logic [2*GL_IDX_W-1:0]         wb_index_o,
  output logic [2*DATA_W-1:0]           wb_data_o,
  output logic [$clog2(NUM_REQ+1)-1:0]  pending_o
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]                hv, grant, load;
  logic [NUM_REQ-1:0][GL_IDX_W-1:0]  hidx;
  logic [NUM_REQ-1:0][DATA_W-1:0]    hdata;
  logic [PTR_W-1:0]                  rr_ptr, rr_ptr_nxt, sel0, sel1, cand, last;
  logic [SUM_W-1:0]                  sum;
  logic                              vld0, vld1;

  assign req_ready_o = (~hv | grant) & {NUM_REQ{~flush_i}};
  assign load        = req_valid_i & req_ready_o;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_hold
    gl_wb_hold #(.GL_IDX_W(GL_IDX_W), .DATA_W(DATA_W)) u_hold (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .flush (flush_i),
      .load  (load[r]),
      .grant (grant[r]),
      .idx   (req_index_i[r*GL_IDX_W +: GL_IDX_W]),
      .data  (req_data_i[r*DATA_W +: DATA_W]),
      .hv    (hv[r]),
      .hidx  (hidx[r]),
      .hdata (hdata[r])
    );
  end

  // Scan starting at rr_ptr and wrapping modulo NUM_REQ. The first two held entries found take ports 0 and 1.
  always_comb begin
    grant = '0;
    vld0  = 1'b0;
    vld1  = 1'b0;
    sel0  = '0;
    sel1  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = SUM_W'(rr_ptr) + SUM_W'(k);
      cand = (sum >= SUM_W'(NUM_REQ)) ? PTR_W'(sum - SUM_W'(NUM_REQ)) : PTR_W'(sum);
      if (hv[cand] && !flush_i) begin
        if (!vld0) begin
          vld0        = 1'b1;
          sel0        = cand;
          grant[cand] = 1'b1;
        end else if (!vld1) begin
          vld1        = 1'b1;
          sel1        = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last       = vld1 ? sel1 : sel0;
    rr_ptr_nxt = rr_ptr;
    if (flush_i)   rr_ptr_nxt = '0;
    else if (vld0) rr_ptr_nxt = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr      <= '0;
      wb_enable_o <= '0;
      wb_index_o  <= '0;
      wb_data_o   <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      wb_enable_o <= {vld1, vld0};
      if (vld0) begin
        wb_index_o[0 +: GL_IDX_W] <= hidx[sel0];
        wb_data_o[0 +: DATA_W]    <= hdata[sel0];
      end
      if (vld1) begin
        wb_index_o[GL_IDX_W +: GL_IDX_W] <= hidx[sel1];
        wb_data_o[DATA_W +: DATA_W]      <= hdata[sel1];
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < NUM_REQ; r++) pending_o = pending_o + CNT_W'(hv[r]);
  end

  // Two live buffers must never carry the same GL entry.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_uniq_i
    for (genvar j = i + 1; j < NUM_REQ; j++) begin : g_uniq_j
      a_uniq_idx: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(hv[i] && hv[j] && hidx[i] == hidx[j]));
    end
  end
endmodule
